multicycle_controller: RTL and testbench

Control unit for the multicycle MIPS datapath driven by `top`. It sequences one shared memory, one ALU and the register file through a Moore state machine. For each state it drives the mux selects, register write enables and the combined PC enable. It also contains the ALU decoder that maps ALUOp and funct to the 3-bit ALU control.

---
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control unit for the multicycle MIPS datapath.
// It sequences fetch/decode/execute/memory/write-back states, drives the
// mux selects and write strobes for each state, and decodes ALUOp/funct into
// the 3-bit ALU control.
// Optional feature: define MCTRL_BNE_EN to add the bne instruction
// (BRANCHNE state, encoding 12). With the macro undefined, bne is illegal
// and encoding 12 is treated like the other unreachable encodings.
// Reset is asynchronous and active-high. While it is asserted, every write
// strobe (pcen, memwrite, irwrite, regwrite) is held low, so an aborted
// instruction never performs a partial write.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      BRANCHNE = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCTRL_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   state_t state_q;
   state_t state_d;

   // Raw (pre-reset-gating) per-state control values
   logic       pcwrite_s;
   logic       branch_s;
   logic       memwrite_s;
   logic       irwrite_s;
   logic       regwrite_s;
   logic [1:0] aluop_s;
`ifdef MCTRL_BNE_EN
   logic       branchne_s;
`endif

   // State register: asynchronous reset returns straight to FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection; any unknown opcode or encoding falls back to FETCH
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
`ifdef MCTRL_BNE_EN
               OP_BNE:       state_d = BRANCHNE;
`endif
               default:      state_d = FETCH;
            endcase
         end
         // MEMADR is only reached for lw or sw, so sw picks MEMWR, else MEMRD
         MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = FETCH;
         EXECUTE: state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB:  state_d = FETCH;
         JUMP:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Moore decode of selects and raw strobes from the current state
   always_comb begin
      pcwrite_s  = 1'b0;
      branch_s   = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      aluop_s    = 2'b00;
`ifdef MCTRL_BNE_EN
      branchne_s = 1'b0;
`endif
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      case (state_q)
         FETCH: begin
            alusrcb   = 2'b01;
            pcwrite_s = 1'b1;
            irwrite_s = 1'b1;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop_s = 2'b10;
         end
         ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         BRANCH: begin
            alusrca  = 1'b1;
            aluop_s  = 2'b01;
            pcsrc    = 2'b01;
            branch_s = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:  regwrite_s = 1'b1;
         JUMP: begin
            pcsrc     = 2'b10;
            pcwrite_s = 1'b1;
         end
`ifdef MCTRL_BNE_EN
         BRANCHNE: begin
            alusrca    = 1'b1;
            aluop_s    = 2'b01;
            pcsrc      = 2'b01;
            branchne_s = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Write strobes, held low for the whole time reset is asserted
   always_comb begin
      memwrite = memwrite_s & ~reset;
      irwrite  = irwrite_s  & ~reset;
      regwrite = regwrite_s & ~reset;
`ifdef MCTRL_BNE_EN
      pcen = (pcwrite_s | (branch_s & zero) | (branchne_s & ~zero)) & ~reset;
`else
      pcen = (pcwrite_s | (branch_s & zero)) & ~reset;
`endif
   end

   // ALU decoder: add by default, subtract for branches, funct for R-type
   always_comb begin
      alucontrol = 3'b010;
      case (aluop_s)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed bench for multicycle_controller.
// The driver pushes one expected output vector per clock cycle into exp_q;
// a monitor on the falling edge pops and compares it with the DUT outputs.
// Define MCTRL_BNE_EN on both bench and design to exercise bne.
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   // Vector: {state[3:0], pcen, memwrite, irwrite, regwrite, iord, memtoreg,
   //          regdst, alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
   localparam int W = 19;
   localparam logic [W-1:0] RESET_VEC = {4'd0, 8'b0000_0000, 2'b01, 2'b00, 3'b010};

   logic [W-1:0] exp_q[$];
   int compared;
   int mismatched;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .state      (state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] cur_vec();
      return {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg,
              regdst, alusrca, alusrcb, pcsrc, alucontrol};
   endfunction

   // Hand-written expected outputs per state.
   // Strobe byte order: pcen memwrite irwrite regwrite iord memtoreg regdst alusrca
   function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic z,
                                            input logic [2:0] alu6);
      logic [7:0] stb;
      logic [1:0] b;
      logic [1:0] p;
      logic [2:0] a;
      stb = 8'b0; b = 2'b00; p = 2'b00; a = 3'b010;
      case (st)
         4'd0:  begin stb = 8'b1010_0000; b = 2'b01; end
         4'd1:  b = 2'b11;
         4'd2:  begin stb = 8'b0000_0001; b = 2'b10; end
         4'd3:  stb = 8'b0000_1000;
         4'd4:  stb = 8'b0001_0100;
         4'd5:  stb = 8'b0100_1000;
         4'd6:  begin stb = 8'b0000_0001; a = alu6; end
         4'd7:  stb = 8'b0001_0010;
         4'd8:  begin stb = {z, 7'b000_0001}; p = 2'b01; a = 3'b110; end
         4'd9:  begin stb = 8'b0000_0001; b = 2'b10; end
         4'd10: stb = 8'b0001_0000;
         4'd11: begin stb = 8'b1000_0000; p = 2'b10; end
         4'd12: begin stb = {~z, 7'b000_0001}; p = 2'b01; a = 3'b110; end
         default: ;
      endcase
      return {st, stb, b, p, a};
   endfunction

   task automatic compare(input string name, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got state=%0d strobes=%b alusrcb=%b pcsrc=%b alu=%b, expected state=%0d strobes=%b alusrcb=%b pcsrc=%b alu=%b",
                  name, act[18:15], act[14:7], act[6:5], act[4:3], act[2:0],
                  exp[18:15], exp[14:7], exp[6:5], exp[4:3], exp[2:0]);
      end
   endtask

   // Monitor: one comparison per cycle on the falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         compare($sformatf("cycle_state%0d_t%0t", e[18:15], $time), cur_vec(), e);
      end
   end

   // Driver: called at posedge+1 with the DUT in FETCH; seq holds up to five
   // 4-bit states (first state in the top nibble), n of them are used.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input logic [2:0] alu6,
                            input logic [19:0] seq, input int n);
      op = o; funct = f; zero = z;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(exp_vec(seq[19-4*i -: 4], z, alu6));
         @(posedge clk);
         #1;
      end
   endtask

   // Reset pulse while sitting in state st (called at posedge+1)
   task automatic abort_reset(input logic [3:0] st);
      exp_q.push_back(exp_vec(st, zero, 3'b010));
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      compare("abort_async_reset", cur_vec(), RESET_VEC);
      exp_q.push_back(RESET_VEC);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Watchdog
   initial begin
      #200000;
      mismatched++;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Stimulus
   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
      #2;
      reset = 1'b1;
      exp_q.push_back(RESET_VEC);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // lw: 0,1,2,3,4
      run_instr(6'b100011, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
      // R-type slt, or, and, sub, unknown funct
      run_instr(6'b000000, 6'b101010, 1'b0, 3'b111, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      run_instr(6'b000000, 6'b100101, 1'b0, 3'b001, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      run_instr(6'b000000, 6'b100100, 1'b1, 3'b000, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      run_instr(6'b000000, 6'b100010, 1'b0, 3'b110, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      run_instr(6'b000000, 6'b100000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      run_instr(6'b000000, 6'b000111, 1'b0, 3'b010, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);
      // beq taken and not taken
      run_instr(6'b000100, 6'b000000, 1'b1, 3'b010, {4'd0, 4'd1, 4'd8, 8'd0}, 3);
      run_instr(6'b000100, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd8, 8'd0}, 3);
      // sw, j, addi
      run_instr(6'b101011, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4);
      run_instr(6'b000010, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd11, 8'd0}, 3);
      run_instr(6'b001000, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, 4);
      // Illegal opcode: NOP
      run_instr(6'b111111, 6'b000000, 1'b1, 3'b010, {4'd0, 4'd1, 12'd0}, 2);
      // bne
`ifdef MCTRL_BNE_EN
      run_instr(6'b000101, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd12, 8'd0}, 3);
      run_instr(6'b000101, 6'b000000, 1'b1, 3'b010, {4'd0, 4'd1, 4'd12, 8'd0}, 3);
`else
      run_instr(6'b000101, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 12'd0}, 2);
`endif
      // lw aborted by reset while in MEMRD, then a full lw afterwards
      run_instr(6'b100011, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd2, 8'd0}, 3);
      abort_reset(4'd3);
      run_instr(6'b100011, 6'b000000, 1'b0, 3'b010, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
      // Back in FETCH after the last instruction
      run_instr(6'b111111, 6'b000000, 1'b0, 3'b010, {4'd0, 16'd0}, 1);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
